// File: rtl/io_handshake_controller.sv
// Sequences processor IN/OUT instructions against the board switches and a
// synchronized, debounced enter key; stalls the core until a fresh press.
module io_handshake_controller #(
  parameter int unsigned DATA_WIDTH      = 18,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] entrada,
  input  logic                  enter,
  input  logic                  in_req,
  input  logic                  out_req,
  input  logic [DATA_WIDTH-1:0] out_data,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] display,
  output logic                  waiting_in,
  output logic                  waiting_out
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ARM        = 2'd1,
    WAIT_PRESS = 2'd2,
    DONE       = 2'd3
  } state_t;

  typedef enum logic {
    OP_IN  = 1'b0,
    OP_OUT = 1'b1
  } op_t;

  state_t state, state_d;
  op_t    op, op_d;

  logic                  enter_meta, enter_s, enter_db;
  logic [CNT_W-1:0]      db_cnt;
  logic                  done_d, waiting_in_d, waiting_out_d;
  logic [DATA_WIDTH-1:0] in_data_d, display_d;

  // Two-flop synchronizer for the asynchronous enter key
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enter_meta <= 1'b0;
      enter_s    <= 1'b0;
    end else begin
      enter_meta <= enter;
      enter_s    <= enter_meta;
    end
  end

  // Debounce: level only follows enter_s after DEBOUNCE_CYCLES stable cycles
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt   <= '0;
      enter_db <= 1'b0;
    end else if (enter_s == enter_db) begin
      db_cnt <= '0;
    end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      enter_db <= enter_s;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + CNT_W'(1);
    end
  end

  // State and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      op          <= OP_IN;
      done        <= 1'b0;
      waiting_in  <= 1'b0;
      waiting_out <= 1'b0;
      in_data     <= '0;
      display     <= '0;
    end else begin
      state       <= state_d;
      op          <= op_d;
      done        <= done_d;
      waiting_in  <= waiting_in_d;
      waiting_out <= waiting_out_d;
      in_data     <= in_data_d;
      display     <= display_d;
    end
  end

  // Next state; requests are only looked at in IDLE, IN wins over OUT
  always_comb begin
    state_d   = state;
    op_d      = op;
    in_data_d = in_data;
    display_d = display;
    unique case (state)
      IDLE: begin
        if (in_req) begin
          op_d    = OP_IN;
          state_d = ARM;
        end else if (out_req) begin
          op_d      = OP_OUT;
          display_d = out_data;
          state_d   = ARM;
        end
      end
      // A press held over from the previous operation must be released first
      ARM: begin
        if (!enter_db) state_d = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        if (enter_db) begin
          if (op == OP_IN) in_data_d = entrada;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    done_d        = (state_d == DONE);
    waiting_in_d  = (op_d == OP_IN)  && ((state_d == ARM) || (state_d == WAIT_PRESS));
    waiting_out_d = (op_d == OP_OUT) && ((state_d == ARM) || (state_d == WAIT_PRESS));
  end

  // Combinational so the core freezes in the very cycle it raises a request
  always_comb begin
    stall = 1'b0;
    unique case (state)
      IDLE:              stall = in_req | out_req;
      ARM, WAIT_PRESS:   stall = 1'b1;
      default:           stall = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_io_handshake_controller.sv
// Directed bench for io_handshake_controller with a short debounce window.
module tb_io_handshake_controller;

  localparam int unsigned DW = 18;

  logic          clock;
  logic          reset_n;
  logic [DW-1:0] entrada;
  logic          enter;
  logic          in_req;
  logic          out_req;
  logic [DW-1:0] out_data;
  logic          stall;
  logic          done;
  logic [DW-1:0] in_data;
  logic [DW-1:0] display;
  logic          waiting_in;
  logic          waiting_out;

  int compared   = 0;
  int mismatched = 0;
  int done_cnt;
  logic seen_wo;

  io_handshake_controller #(
    .DATA_WIDTH(DW),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .entrada    (entrada),
    .enter      (enter),
    .in_req     (in_req),
    .out_req    (out_req),
    .out_data   (out_data),
    .stall      (stall),
    .done       (done),
    .in_data    (in_data),
    .display    (display),
    .waiting_in (waiting_in),
    .waiting_out(waiting_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Runs n cycles acting as the core: counts done pulses and drops requests on done
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (waiting_out === 1'b1) seen_wo = 1'b1;
      if (done === 1'b1) begin
        done_cnt++;
        check("stall_in_done", 32'(stall), 32'd0);
        check("waiting_in_done", 32'(waiting_in), 32'd0);
        in_req  = 1'b0;
        out_req = 1'b0;
      end
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    entrada  = '0;
    enter    = 1'b0;
    in_req   = 1'b0;
    out_req  = 1'b0;
    out_data = '0;
    #2;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_in_data", 32'(in_data), 32'd0);
    check("rst_display", 32'(display), 32'd0);
    check("rst_waiting", {30'd0, waiting_in, waiting_out}, 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // 1: IN, enter starts low
    entrada = 18'h2A5A5;
    in_req  = 1'b1;
    #1;
    check("t1_stall_req", 32'(stall), 32'd1);
    tick();
    check("t1_waiting_in", 32'(waiting_in), 32'd1);
    check("t1_stall_arm", 32'(stall), 32'd1);
    tick();
    enter    = 1'b1;
    done_cnt = 0;
    run_cycles(10);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_in_data", 32'(in_data), 32'h2A5A5);
    check("t1_waiting_after", 32'(waiting_in), 32'd0);
    check("t1_stall_after", 32'(stall), 32'd0);
    enter = 1'b0;
    repeat (8) tick();

    // 2: OUT
    out_data = 18'h00123;
    out_req  = 1'b1;
    tick();
    check("t2_display_accept", 32'(display), 32'h00123);
    check("t2_waiting_out", 32'(waiting_out), 32'd1);
    check("t2_waiting_in", 32'(waiting_in), 32'd0);
    out_data = 18'h3FFFF;
    tick();
    enter    = 1'b1;
    done_cnt = 0;
    run_cycles(10);
    check("t2_done_cnt", 32'(done_cnt), 32'd1);
    check("t2_display_hold", 32'(display), 32'h00123);
    check("t2_in_data_hold", 32'(in_data), 32'h2A5A5);
    enter = 1'b0;
    repeat (8) tick();

    // 3: enter already held when the IN arrives
    enter = 1'b1;
    repeat (8) tick();
    entrada  = 18'h15A5A;
    in_req   = 1'b1;
    done_cnt = 0;
    run_cycles(10);
    check("t3_no_done_held", 32'(done_cnt), 32'd0);
    check("t3_stall_held", 32'(stall), 32'd1);
    enter = 1'b0;
    run_cycles(6);
    enter = 1'b1;
    run_cycles(6);
    enter = 1'b0;
    run_cycles(8);
    check("t3_done_cnt", 32'(done_cnt), 32'd1);
    check("t3_in_data", 32'(in_data), 32'h15A5A);

    // 4: bounce shorter than the debounce window
    entrada = 18'h0F0F0;
    in_req  = 1'b1;
    repeat (2) tick();
    done_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      enter = 1'b1;
      run_cycles(3);
      enter = 1'b0;
      run_cycles(3);
    end
    check("t4_no_done", 32'(done_cnt), 32'd0);
    check("t4_stall", 32'(stall), 32'd1);
    check("t4_waiting_in", 32'(waiting_in), 32'd1);
    check("t4_in_data_hold", 32'(in_data), 32'h15A5A);
    enter = 1'b1;
    run_cycles(10);
    check("t4_done_cnt", 32'(done_cnt), 32'd1);
    check("t4_in_data", 32'(in_data), 32'h0F0F0);
    enter = 1'b0;
    repeat (8) tick();

    // 5: simultaneous requests, IN has priority
    entrada  = 18'h0BEEF;
    out_data = 18'h3ABCD;
    in_req   = 1'b1;
    out_req  = 1'b1;
    seen_wo  = 1'b0;
    tick();
    check("t5_waiting_in", 32'(waiting_in), 32'd1);
    check("t5_display_accept", 32'(display), 32'h00123);
    tick();
    enter    = 1'b1;
    done_cnt = 0;
    run_cycles(10);
    check("t5_done_cnt", 32'(done_cnt), 32'd1);
    check("t5_in_data", 32'(in_data), 32'h0BEEF);
    check("t5_display", 32'(display), 32'h00123);
    check("t5_waiting_out_seen", 32'(seen_wo), 32'd0);
    enter = 1'b0;
    repeat (8) tick();

    // 6: async reset while waiting for a press
    entrada = 18'h12345;
    in_req  = 1'b1;
    repeat (3) tick();
    check("t6_waiting_pre", 32'(waiting_in), 32'd1);
    #3;
    reset_n = 1'b0;
    in_req  = 1'b0;
    #1;
    check("t6_rst_waiting", 32'(waiting_in), 32'd0);
    check("t6_rst_in_data", 32'(in_data), 32'd0);
    check("t6_rst_display", 32'(display), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    check("t6_rst_stall", 32'(stall), 32'd0);
    done_cnt = 0;
    run_cycles(2);
    reset_n = 1'b1;
    run_cycles(2);
    check("t6_no_done", 32'(done_cnt), 32'd0);
    entrada = 18'h2C3D4;
    in_req  = 1'b1;
    repeat (2) tick();
    enter = 1'b1;
    run_cycles(10);
    check("t6_done_cnt", 32'(done_cnt), 32'd1);
    check("t6_in_data", 32'(in_data), 32'h2C3D4);
    enter = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
